gene_collector: RTL and testbench
=================================

// Module: gene_collector
// PURPOSE
//  Receiving end of the evolution PE output interface: accepts up to three child genes
//  per cycle (gene_in1..3 qualified by in_valid[2:0]) and compacts them in order into a
//  multi-write FIFO. Drains one gene per cycle to the genome memory writer over a
//  valid/ready handshake. Tags the last gene of each genome and reports per-genome counts.
// PARAMETERS
//  GENE_SZ  64  width of one gene word
//  DEPTH    16  FIFO entries; power of two, >= 4
//  CNT_SZ   16  width of per-genome gene counter
// PORTS
//  clk          input   1        clock, all logic on rising edge
//  rst          input   1        asynchronous, active-low reset
//  gene_in1     input   GENE_SZ  lane 0 gene
//  gene_in2     input   GENE_SZ  lane 1 gene
//  gene_in3     input   GENE_SZ  lane 2 gene
//  in_valid     input   3        bit k qualifies gene_in(k+1)
//  genome_end   input   1        current beat is the final beat of a genome
//  in_ready     output  1        beat accepted this cycle when high
//  gene_out     output  GENE_SZ  head-of-FIFO gene
//  out_last     output  1        gene_out is the last gene of its genome
//  out_valid    output  1        gene_out/out_last valid
//  out_ready    input   1        downstream accepts gene_out
//  genome_cnt   output  CNT_SZ   gene count of the most recently ended genome
//  cnt_valid    output  1        one-cycle pulse: genome_cnt updated
// BEHAVIOUR
//  Reset (rst=0, async): pointers, occupancy, running count cleared; in_ready=1,
//   out_valid=0, out_last=0, gene_out=0, genome_cnt=0, cnt_valid=0. Reset mid-operation
//   discards all stored genes and the partial genome count.
//  in_ready = (DEPTH - occ) >= 3; combinational from the occupancy register only (never
//   from out_ready). Beat accepted iff in_ready=1; sender holds the beat otherwise; a
//   non-accepted beat writes nothing and does not affect counts.
//  Packing: n = popcount(in_valid). Valid lanes written in lane order 1,2,3 to consecutive
//   slots wr_ptr, wr_ptr+1, ... (mod DEPTH); invalid lanes skipped, no holes.
//   e.g. in_valid=3'b101 -> gene_in1 @wr_ptr, gene_in3 @wr_ptr+1; wr_ptr += 2.
//  Each entry stores {last, gene}; last=1 only on the highest-order valid lane of an
//   accepted beat with genome_end=1.
//  Output: first-word fall-through; out_valid = (occ != 0); pop = out_valid & out_ready;
//   rd_ptr += pop. Write-to-out_valid latency 1 cycle (registered occupancy).
//  occ_next = occ + n(accepted) - pop; simultaneous push/pop legal at any occupancy,
//   including full-3 and empty. Pointers are log2(DEPTH) bits, wrap naturally.
//  Counting: running count += n per accepted beat, saturating at 2^CNT_SZ-1. On accepted
//   genome_end: genome_cnt <= running+n (saturated), cnt_valid pulses 1 cycle, running <= 0.
//  genome_end with in_valid=0: no FIFO write, no out_last emitted; genome_cnt and
//   cnt_valid still updated (zero-length final beat; consumer relies on genome_cnt).
//  in_valid=0 and genome_end=0: no-op even when in_ready=1.
// STRUCTURE
//  Shared package gene_pkg: GENE_SZ/ATTR_SZ defaults, popcount3 function, lane-order
//   constants (shared with the PE lane logic).
//  Sub-module gene_fifo_mw: DEPTH x (GENE_SZ+1) storage, 3-write/1-read ports, pointer
//   and occupancy logic. Top holds compaction, last tagging, counters.
// TESTING
//  1 reset: drive rst=0 mid-stream with occ=5 -> immediately out_valid=0, in_ready=1,
//    genome_cnt=0; first gene after release appears at rd slot 0.
//  2 packing: in_valid=3'b101, gene_in1=A, gene_in3=C, out_ready=1 -> gene_out A then C
//    on consecutive cycles, nothing for lane 2.
//  3 backpressure: DEPTH=16, out_ready=0, 5 beats of 3'b111 -> 15 stored, in_ready=0 from
//    occ=14; sixth beat held; out_ready=1 for 2 cycles -> in_ready returns at occ=13.
//  4 wrap + simultaneous: keep occ near 15 with push 3/pop 1 per cycle across pointer wrap
//    -> output sequence equals input order, no loss or duplication (scoreboard).
//  5 genome end: beats 3'b111, 3'b011+genome_end -> out_last only on 5th gene,
//    genome_cnt=5, cnt_valid single pulse; next genome counts from 0.
//  6 empty end: beat 3'b001, then in_valid=0+genome_end -> no out_last, genome_cnt=1.

Source files
------------

// File: rtl/gene_pkg.sv
// Shared definitions for the gene datapath: default widths, lane ordering and
// the lane popcount used by both the PE lane logic and the collector.
package gene_pkg;

  localparam int DEF_GENE_SZ = 64;
  // Attribute bits stored alongside each gene; currently only the last-of-genome flag.
  localparam int ATTR_SZ     = 1;

  // Lane k carries gene_in(k+1); lower lanes are older in genome order.
  localparam int LANE0 = 0;
  localparam int LANE1 = 1;
  localparam int LANE2 = 2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/gene_fifo_mw.sv
// Multi-write FIFO: up to three pre-compacted entries written per cycle at
// consecutive slots, one entry read per cycle, first-word fall-through head.
module gene_fifo_mw
  import gene_pkg::*;
#(
  parameter int W     = DEF_GENE_SZ + ATTR_SZ,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int OW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    i_wr_cnt,
  input  logic [W-1:0]  i_wr_d0,
  input  logic [W-1:0]  i_wr_d1,
  input  logic [W-1:0]  i_wr_d2,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [OW-1:0] o_occ
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;

  // Pointers are exactly log2(DEPTH) bits so the modulo wrap is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_wr_cnt);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop);
      r_occ    <= r_occ + OW'(i_wr_cnt) - OW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_cnt != 2'd0) r_mem[r_wr_ptr]          <= i_wr_d0;
    if (i_wr_cnt >= 2'd2) r_mem[r_wr_ptr + PW'(1)] <= i_wr_d1;
    if (i_wr_cnt == 2'd3) r_mem[r_wr_ptr + PW'(2)] <= i_wr_d2;
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/gene_collector.sv
// Collects up to three child genes per cycle, compacts them into a multi-write
// FIFO, tags the last gene of each genome and reports per-genome gene counts.
module gene_collector
  import gene_pkg::*;
#(
  parameter int GENE_SZ = DEF_GENE_SZ,
  parameter int DEPTH   = 16,
  parameter int CNT_SZ  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [GENE_SZ-1:0] gene_in1,
  input  logic [GENE_SZ-1:0] gene_in2,
  input  logic [GENE_SZ-1:0] gene_in3,
  input  logic [2:0]         in_valid,
  input  logic               genome_end,
  output logic               in_ready,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_SZ-1:0]  genome_cnt,
  output logic               cnt_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int W  = GENE_SZ + ATTR_SZ;
  localparam int CW = CNT_SZ + 1;
  localparam logic [OW-1:0] MAX_OCC = OW'(DEPTH - 3);

  logic [OW-1:0]      w_occ;
  logic [W-1:0]       w_head;
  logic [1:0]         w_n;
  logic [1:0]         w_wr_cnt;
  logic               w_pop;
  logic [GENE_SZ-1:0] w_slot0;
  logic [GENE_SZ-1:0] w_slot1;
  logic [GENE_SZ-1:0] w_slot2;
  logic [W-1:0]       w_d0;
  logic [W-1:0]       w_d1;
  logic [W-1:0]       w_d2;
  logic [CW-1:0]      w_sum;
  logic [CNT_SZ-1:0]  w_sat;

  logic [CNT_SZ-1:0]  r_running;
  logic [CNT_SZ-1:0]  r_genome_cnt;
  logic               r_cnt_valid;

  // Handshake: a beat is accepted in any cycle where in_ready is high (the
  // sender holds it otherwise); a head gene is consumed when out_valid and
  // out_ready are both high. in_ready depends only on stored occupancy so a
  // full beat of three always fits regardless of what the reader does.
  assign in_ready  = (w_occ <= MAX_OCC);
  assign out_valid = (w_occ != '0);
  assign w_pop     = out_valid & out_ready;
  assign gene_out  = out_valid ? w_head[GENE_SZ-1:0] : '0;
  assign out_last  = out_valid & w_head[GENE_SZ];

  assign w_n      = popcount3(in_valid);
  assign w_wr_cnt = in_ready ? w_n : 2'd0;

  // Slot k takes the (k+1)-th valid lane in lane order.
  always_comb begin
    w_slot0 = gene_in3;
    if (in_valid[LANE1]) w_slot0 = gene_in2;
    if (in_valid[LANE0]) w_slot0 = gene_in1;
    w_slot1 = (in_valid[LANE0] & in_valid[LANE1]) ? gene_in2 : gene_in3;
    w_slot2 = gene_in3;
  end

  // The highest valid lane always lands in slot n-1.
  assign w_d0 = {genome_end & (w_n == 2'd1), w_slot0};
  assign w_d1 = {genome_end & (w_n == 2'd2), w_slot1};
  assign w_d2 = {genome_end & (w_n == 2'd3), w_slot2};

  gene_fifo_mw #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .i_wr_cnt (w_wr_cnt),
    .i_wr_d0  (w_d0),
    .i_wr_d1  (w_d1),
    .i_wr_d2  (w_d2),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_occ    (w_occ)
  );

  assign w_sum = {1'b0, r_running} + CW'(w_n);
  assign w_sat = w_sum[CNT_SZ] ? '1 : w_sum[CNT_SZ-1:0];

  // A genome_end beat with no valid lanes still closes the genome.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_running    <= '0;
      r_genome_cnt <= '0;
      r_cnt_valid  <= 1'b0;
    end else begin
      r_cnt_valid <= 1'b0;
      if (in_ready) begin
        if (genome_end) begin
          r_genome_cnt <= w_sat;
          r_cnt_valid  <= 1'b1;
          r_running    <= '0;
        end else if (w_n != 2'd0) begin
          r_running <= w_sat;
        end
      end
    end
  end

  assign genome_cnt = r_genome_cnt;
  assign cnt_valid  = r_cnt_valid;

endmodule

// File: tb/tb_gene_collector.sv
// Directed bench for gene_collector: scoreboard of {last, gene} entries plus a
// model of occupancy, ready/valid and genome counts checked every cycle.
module tb_gene_collector;

  localparam int GENE_SZ = 64;
  localparam int DEPTH   = 16;
  localparam int CNT_SZ  = 16;
  localparam int W       = GENE_SZ + 1;

  logic               clk;
  logic               rst;
  logic [GENE_SZ-1:0] gene_in1;
  logic [GENE_SZ-1:0] gene_in2;
  logic [GENE_SZ-1:0] gene_in3;
  logic [2:0]         in_valid;
  logic               genome_end;
  logic               in_ready;
  logic [GENE_SZ-1:0] gene_out;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_SZ-1:0]  genome_cnt;
  logic               cnt_valid;

  gene_collector #(
    .GENE_SZ (GENE_SZ),
    .DEPTH   (DEPTH),
    .CNT_SZ  (CNT_SZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gene_in1   (gene_in1),
    .gene_in2   (gene_in2),
    .gene_in3   (gene_in3),
    .in_valid   (in_valid),
    .genome_end (genome_end),
    .in_ready   (in_ready),
    .gene_out   (gene_out),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .genome_cnt (genome_cnt),
    .cnt_valid  (cnt_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and model state
  logic [W-1:0]      exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                m_sz;
  int                m_hi;
  logic              m_ready;
  logic              m_acc = 1'b0;
  logic              m_pend = 1'b0;
  logic [CNT_SZ-1:0] m_gcnt = '0;
  int                m_run = 0;
  int                m_n;
  logic [GENE_SZ-1:0] m_lane [3];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model by one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_run  = 0;
      m_gcnt = '0;
      m_pend = 1'b0;
      m_acc  = 1'b0;
    end else begin
      m_sz    = exp_q.size();
      m_ready = ((DEPTH - m_sz) >= 3);
      chk("out_valid", W'(out_valid), W'(m_sz != 0));
      chk("in_ready", W'(in_ready), W'(m_ready));
      chk("cnt_valid", W'(cnt_valid), W'(m_pend));
      chk("genome_cnt", W'(genome_cnt), W'(m_gcnt));
      if (m_sz != 0) begin
        chk("head", {out_last, gene_out}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      m_pend = 1'b0;
      m_acc  = m_ready;
      if (m_ready) begin
        m_lane[0] = gene_in1;
        m_lane[1] = gene_in2;
        m_lane[2] = gene_in3;
        m_hi = -1;
        m_n  = 0;
        for (int k = 0; k < 3; k++) begin
          if (in_valid[k]) begin
            m_hi = k;
            m_n++;
          end
        end
        for (int k = 0; k < 3; k++) begin
          if (in_valid[k]) exp_q.push_back({genome_end && (k == m_hi), m_lane[k]});
        end
        m_run = m_run + m_n;
        if (m_run > 65535) m_run = 65535;
        if (genome_end) begin
          m_gcnt = CNT_SZ'(m_run);
          m_pend = 1'b1;
          m_run  = 0;
        end
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [2:0] v, input logic [GENE_SZ-1:0] a,
                      input logic [GENE_SZ-1:0] b, input logic [GENE_SZ-1:0] c,
                      input logic e);
    int waited;
    waited     = 0;
    in_valid   = v;
    gene_in1   = a;
    gene_in2   = b;
    gene_in3   = c;
    genome_end = e;
    do begin
      @(posedge clk);
      waited++;
    end while (!m_acc && waited < 100);
    chk("accept_timeout", W'(m_acc), W'(1));
    #1;
  endtask

  task automatic idle();
    in_valid   = 3'b000;
    genome_end = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited    = 0;
    idle();
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    chk("drain_timeout", W'(exp_q.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] v;
    rst       = 1'b0;
    gene_in1  = '0;
    gene_in2  = '0;
    gene_in3  = '0;
    in_valid  = 3'b000;
    genome_end = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_gene_out", W'(gene_out), W'(0));
    chk("rst_out_last", W'(out_last), W'(0));
    chk("rst_genome_cnt", W'(genome_cnt), W'(0));
    chk("rst_cnt_valid", W'(cnt_valid), W'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Packing: lane 2 skipped.
    out_ready = 1'b1;
    send(3'b101, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002, 64'hCCCC_0000_0000_0003, 1'b0);
    idle();
    @(posedge clk); #1;
    send(3'b010, 64'h0, 64'h2222_0000_0000_0022, 64'h0, 1'b0);
    send(3'b110, 64'h0, 64'h3333_0000_0000_0032, 64'h3333_0000_0000_0033, 1'b1);
    drain();

    // Genome end tagging: 3 + 2 genes, count 5, then next genome from 0.
    send(3'b111, 64'h5000_0001, 64'h5000_0002, 64'h5000_0003, 1'b0);
    send(3'b011, 64'h5000_0004, 64'h5000_0005, 64'h5000_0006, 1'b1);
    send(3'b001, 64'h6000_0001, 64'h0, 64'h0, 1'b1);
    idle();
    drain();

    // Empty final beat.
    send(3'b001, 64'h7000_0001, 64'h0, 64'h0, 1'b0);
    send(3'b000, 64'h0, 64'h0, 64'h0, 1'b1);
    idle();
    drain();

    // Backpressure: 15 stored, sixth beat held until occupancy falls to 13.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(3'b111, 64'h8000_0000 + 64'(3*i), 64'h8000_0001 + 64'(3*i), 64'h8000_0002 + 64'(3*i), 1'b0);
    fork
      send(3'b111, 64'h9000_0001, 64'h9000_0002, 64'h9000_0003, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
      end
    join
    idle();
    drain();

    // Wrap with simultaneous push/pop near full.
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b111;
      send(v, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 5) == 0);
    end
    idle();
    drain();

    // Reset mid-stream with occupancy 5 and a partial genome count.
    out_ready = 1'b0;
    send(3'b111, 64'hD000_0001, 64'hD000_0002, 64'hD000_0003, 1'b0);
    send(3'b011, 64'hD000_0004, 64'hD000_0005, 64'h0, 1'b0);
    idle();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_genome_cnt", W'(genome_cnt), W'(0));
    chk("midrst_gene_out", W'(gene_out), W'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    send(3'b001, 64'hE000_0001, 64'h0, 64'h0, 1'b1);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
